// File: rtl/moore_seq_detector_param.sv
// rtl/moore_seq_detector_param.sv - parametrised Moore serial pattern detector with stallable input
// Optional saturating match counter built only when SEQDET_COUNT_EN is defined.
module moore_seq_detector_param #(
    parameter int                  PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1010,
    parameter int                  CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    localparam int                FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_n;
    logic [PAT_LEN-1:0] hist_shift;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_n;
    logic [FILL_W-1:0]  fill_inc;
    logic               out_n;
    logic               hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
            out  <= 1'b0;
        end else begin
            hist <= hist_n;
            fill <= fill_n;
            out  <= out_n;
        end
    end

    always_comb begin
        hist_shift = {hist[PAT_LEN-2:0], in};
        fill_inc   = (fill == FULL) ? fill : fill + FILL_W'(1);
        hit        = in_valid && (fill_inc == FULL) && (hist_shift == PATTERN);

        hist_n = hist;
        fill_n = fill;
        out_n  = 1'b0;
        if (clr) begin
            fill_n = '0;
        end else if (in_valid) begin
            hist_n = hist_shift;
            // Non-overlap mode forces a full refill before the next match can fire.
            fill_n = (hit && !overlap) ? '0 : fill_inc;
            out_n  = hit;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (hit && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: doc/moore_seq_detector_param.md
# moore_seq_detector_param

Parametrised Moore-style serial sequence detector that generalises the team's fixed-pattern, non-overlapping detectors. It matches a compile-time pattern of configurable length, supports overlapping and non-overlapping detection selectable at run time, and accepts a qualified (stallable) bit stream. It also keeps an optional saturating match counter. It sits at the end of a serial receive path and pulses a registered `out` flag once per detected pattern.

## Interface
Parameters:
- `PAT_LEN`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1010: pattern to detect, `PAT_LEN` bits wide. The MSB is the first bit received.
- `CNT_W`, 8: width of `match_count`; legal range 1..32.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset. Assertion clears all state immediately. Deassertion is synchronised externally.
- `in_valid`  input  1  qualifies `in`; a bit is accepted only on edges where `in_valid`=1.
- `in`  input  1  serial data bit.
- `overlap`  input  1  1 = overlapping detection, 0 = non-overlapping. Sampled with each accepted bit.
- `clr`  input  1  synchronous clear of history, fill count, `out` and `match_count`.
- `out`  output  1  registered match pulse. High for exactly one cycle per detection.
- `match_count`  output  `CNT_W`  number of detections, saturating.

## Operation
- State consists of:
  - `hist[PAT_LEN-1:0]`: shift history.
  - `fill`: 0..`PAT_LEN` valid-bit count, `$clog2(PAT_LEN+1)` bits.
  - `out` register.
  - `match_count` register.
- On an accepted bit:
  - Next history: `hist_n = {hist[PAT_LEN-2:0], in}`.
  - Next fill: `fill_n = min(fill+1, PAT_LEN)`.
- Match condition: `hit = (fill_n == PAT_LEN) && (hist_n == PATTERN)`.
- When `hit`=1:
  - `out` <= 1.
  - If `overlap`=0, `fill` <= 0. `hist` still loads `hist_n`, but its contents are ignored until refilled.
  - If `overlap`=1, `fill` stays at `PAT_LEN`, so a suffix of the match may start the next one.
- When `hit`=0: `out` <= 0, and `hist`/`fill` take their next values.
- When `in_valid`=0: `hist`, `fill` and `match_count` hold; `out` <= 0. A stall never breaks a partial match.
- `clr`=1 has priority over `in_valid`. It sets `fill` <= 0, `out` <= 0 and `match_count` <= 0. `hist` may hold or load; either is acceptable.
- `match_count` increments on every `hit` and saturates at 2^`CNT_W`-1, with no wrap-around.
- Changing `overlap` affects only the match handling of the bit accepted on that edge. No history is discarded.

## Timing
- Reset values: `out`=0, `match_count`=0, `fill`=0, `hist`=0.
- Latency: the completing bit is sampled at edge k; `out`=1 from edge k until edge k+1. `match_count` updates at the same edge k.
- `out` is a pure register output, with no combinational path from `in` (Moore).
- Back-to-back detections are possible only in overlap mode, and only when the pattern's self-overlap allows it. The minimum spacing is `PAT_LEN` minus the longest proper border.
- Reset asserted mid-pattern aborts the pattern and clears all state. The first match after release needs `PAT_LEN` fresh accepted bits.
- `clr` and `hit` on the same edge: `clr` wins, giving `out`=0 and `match_count`=0.

## Configuration
- Macro: `SEQDET_COUNT_EN`.
- Defined: the `match_count` register and saturating increment are built as described above.
- Undefined: there is no counter logic, and `match_count` is tied to 0. Port widths are unchanged, and `out` behaviour is identical.

## Test plan
All scenarios use the default parameters, with `in_valid`=1 unless noted. Bit k denotes the k-th accepted bit, counting from 1.

- Reset and idle:
  - Stimulus: `reset`=0 for 2 cycles, then release and hold `in`=0 for 10 cycles.
  - Required response: `out`=0 and `match_count`=0 throughout.
- Non-overlap:
  - Stimulus: `overlap`=0, stream 1,0,1,0,1,0,1,0.
  - Required response: `out` pulses after bit 4 and after bit 8; `match_count`=2.
- Overlap:
  - Stimulus: `overlap`=1, stream 1,0,1,0,1,0,1.
  - Required response: `out` pulses after bits 4 and 6, giving 2 pulses; `match_count`=2. With `overlap`=0 the same stream gives 1 pulse.
- Stall tolerance:
  - Stimulus: stream 1,0,1,0 with `in_valid`=0 for 3 cycles between bits 2 and 3.
  - Required response: exactly one `out` pulse, one cycle after bit 4 is accepted.
- Saturation:
  - Stimulus: `CNT_W`=2, `overlap`=1, 7 overlapping matches.
  - Required response: `match_count` reads 1, 2, 3, 3, 3, 3, 3.
- Abort and clear:
  - Stimulus 1: `reset` asserted after bits 1,0,1, then 0,1,0 sent after release.
  - Required response 1: no pulse.
  - Stimulus 2: `clr` asserted on the edge of a completing bit.
  - Required response 2: `out`=0 and `match_count`=0.
